// File: rtl/osd_char_sequencer.sv
// osd_char_sequencer: schedules OSD character cells, text-buffer addresses and glyph rows per scanline.
// Optional OSD_BLINK_EN: frame counter that blanks seg_enable/char_load while blink is requested.
`ifndef CHARACTER_SEGMENTS
`define CHARACTER_SEGMENTS 8
`endif
module osd_char_sequencer #(
    parameter logic [9:0] OSD_X         = 10'd64,
    parameter logic [9:0] OSD_Y         = 10'd32,
    parameter int         CHARS_PER_ROW = 16,
    parameter int         TEXT_ROWS     = 4,
    parameter int         CHAR_SEGS     = `CHARACTER_SEGMENTS,
    parameter int         CHAR_LINES    = 8,
    parameter int         ADDR_W        = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          line_start,
    input  logic                          blink,
    output logic                          seg_start,
    output logic                          seg_enable,
    output logic [ADDR_W-1:0]             char_addr,
    output logic [$clog2(CHAR_LINES)-1:0] glyph_row,
    output logic                          char_load,
    output logic                          osd_active
);
    localparam int GW = $clog2(CHAR_LINES);
    localparam int SW = $clog2(CHAR_SEGS);
    localparam int CW = $clog2(CHARS_PER_ROW + 1);
    localparam logic [9:0]    WIN_H    = 10'(TEXT_ROWS * CHAR_LINES);
    localparam logic [9:0]    X_M1     = OSD_X - 10'd1;
    localparam logic [SW-1:0] SEG_LAST = SW'(CHAR_SEGS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(CHARS_PER_ROW - 1);

    typedef enum logic [2:0] {IDLE, WAIT_LINE, WAIT_COL, RUN, LINE_DONE} state_t;

    state_t            state;
    logic [9:0]        pix_cnt, line_cnt, line_nxt, rel;
    logic [SW-1:0]     seg_cnt;
    logic [CW-1:0]     char_col;
    logic [ADDR_W-1:0] row_base;
    logic              win_nxt, start_run, seg_en_r, load_r, blank;

    // Window decisions use the line number that takes effect at this edge,
    // so a line_start can be judged on the line it opens.
    assign line_nxt = frame_start ? 10'd0 :
                      (line_start && line_cnt != 10'h3ff) ? line_cnt + 10'd1 : line_cnt;
    assign rel      = line_nxt - OSD_Y;
    assign win_nxt  = line_nxt >= OSD_Y && rel < WIN_H;
    assign row_base = ADDR_W'(rel >> GW) * ADDR_W'(CHARS_PER_ROW);

    // With OSD_X=0 the earliest possible entry is straight off the line_start edge.
    assign start_run = !frame_start &&
                       ((OSD_X == 10'd0 && line_start && state != IDLE && win_nxt) ||
                        (OSD_X != 10'd0 && !line_start && state == WAIT_COL && pix_cnt == X_M1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            seg_cnt    <= '0;
            char_col   <= '0;
            char_addr  <= '0;
            glyph_row  <= '0;
            osd_active <= 1'b0;
            seg_start  <= 1'b0;
            seg_en_r   <= 1'b0;
            load_r     <= 1'b0;
        end else begin
            pix_cnt    <= (line_start || frame_start) ? 10'd0 : pix_cnt + 10'(pix_cnt != 10'h3ff);
            line_cnt   <= line_nxt;
            osd_active <= win_nxt;
            glyph_row  <= rel[GW-1:0];
            seg_start  <= 1'b0;
            load_r     <= 1'b0;
            if (frame_start) begin
                state    <= WAIT_LINE;
                seg_en_r <= 1'b0;
                seg_cnt  <= '0;
                char_col <= '0;
            end else if (start_run) begin
                state     <= RUN;
                seg_start <= 1'b1;
                load_r    <= 1'b1;
                seg_en_r  <= 1'b1;
                seg_cnt   <= '0;
                char_col  <= '0;
                char_addr <= row_base;
            end else if (line_start && state != IDLE) begin
                state    <= win_nxt ? WAIT_COL : WAIT_LINE;
                seg_en_r <= 1'b0;
            end else if (state == RUN) begin
                if (seg_cnt == SEG_LAST) begin
                    seg_cnt <= '0;
                    if (char_col == COL_LAST) begin
                        seg_en_r <= 1'b0;
                        state    <= LINE_DONE;
                    end else begin
                        char_col  <= char_col + CW'(1);
                        seg_start <= 1'b1;
                        load_r    <= 1'b1;
                        char_addr <= char_addr + ADDR_W'(1);
                    end
                end else begin
                    seg_cnt <= seg_cnt + SW'(1);
                end
            end
        end
    end

`ifdef OSD_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (frame_start)
            frame_cnt <= frame_cnt + 6'd1;
    end

    assign blank = blink & frame_cnt[5];
`else
    logic unused_blink;

    assign unused_blink = blink;
    assign blank        = 1'b0;
`endif

    // seg_start keeps pulsing while blanked so the time base stays aligned.
    assign seg_enable = seg_en_r & ~blank;
    assign char_load  = load_r & ~blank;
endmodule

// File: tb/tb_osd_char_sequencer.sv
// tb_osd_char_sequencer: randomized line/frame stimulus checked per line against a cell-count model.
module tb_osd_char_sequencer;
    logic       clk = 0, rst_n = 1, frame_start = 0, line_start = 0, blink = 0;
    logic       seg_start, seg_enable, char_load, osd_active;
    logic [9:0] char_addr;
    logic [2:0] glyph_row;
    int         tests = 0, fails = 0;
    int         cur_line = 0;
    bit         framed = 0;
    int         en_cnt, first_en, last_en, st_cnt, ld_cnt, gap_bad, addr_bad, first_addr, last_addr, last_st;
    logic       act0;
    logic [2:0] glyph0;
    bit         act_var;

    always #5 clk = ~clk;

    osd_char_sequencer dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start), .blink(blink),
        .seg_start(seg_start), .seg_enable(seg_enable), .char_addr(char_addr),
        .glyph_row(glyph_row), .char_load(char_load), .osd_active(osd_active)
    );

    function automatic bit in_win(input int l);
        return l >= 32 && l < 64;
    endfunction

    // Enabled cycles on a line: window columns 64..191, cut short by the line length.
    function automatic int exp_en(input int l, input int len, input bit f);
        if (!f || !in_win(l) || len <= 64) return 0;
        return (len < 192 ? len : 192) - 64;
    endfunction

    // Observes one line of len pixels and issues the next line_start in its final cycle.
    task automatic run_line(input int len, input bit fs_next);
        en_cnt = 0; first_en = -1; last_en = -1; st_cnt = 0; ld_cnt = 0; gap_bad = 0;
        addr_bad = 0; first_addr = -1; last_addr = -1; last_st = -1; act_var = 0;
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            line_start  = (p == len - 1);
            frame_start = line_start & fs_next;
            if (p == 0) begin
                act0 = osd_active;
                glyph0 = glyph_row;
            end else if (osd_active !== act0) act_var = 1;
            if (seg_enable === 1'b1) begin
                en_cnt++;
                if (first_en < 0) first_en = p;
                last_en = p;
            end
            if (seg_start === 1'b1) begin
                if (st_cnt > 0 && p - last_st != 8) gap_bad++;
                if (seg_enable !== 1'b1) gap_bad++;
                st_cnt++;
                last_st = p;
            end
            if (char_load === 1'b1) begin
                if (ld_cnt > 0 && int'(char_addr) != last_addr + 1) addr_bad++;
                if (ld_cnt == 0) first_addr = int'(char_addr);
                last_addr = int'(char_addr);
                ld_cnt++;
            end
        end
        if (fs_next) begin
            cur_line = 0;
            framed = 1;
        end else cur_line++;
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        tests++; if (seg_start !== 1'b0) begin fails++; $display("FAIL reset seg_start got %b exp 0", seg_start); end
        tests++; if (seg_enable !== 1'b0) begin fails++; $display("FAIL reset seg_enable got %b exp 0", seg_enable); end
        tests++; if (char_load !== 1'b0) begin fails++; $display("FAIL reset char_load got %b exp 0", char_load); end
        tests++; if (osd_active !== 1'b0) begin fails++; $display("FAIL reset osd_active got %b exp 0", osd_active); end
        tests++; if (char_addr !== 10'd0) begin fails++; $display("FAIL reset char_addr got %0d exp 0", char_addr); end
        tests++; if (glyph_row !== 3'd0) begin fails++; $display("FAIL reset glyph_row got %0d exp 0", glyph_row); end
        rst_n = 1;
        cur_line = 0;
        framed = 0;
    endtask

    task automatic test_no_frame;
        for (int i = 0; i < 5; i++) begin
            run_line(120, 0);
            tests++; if (en_cnt != 0) begin fails++; $display("FAIL noframe en_cnt got %0d exp 0", en_cnt); end
            tests++; if (st_cnt != 0) begin fails++; $display("FAIL noframe st_cnt got %0d exp 0", st_cnt); end
            tests++; if (act0 !== 1'b0) begin fails++; $display("FAIL noframe osd_active got %b exp 0", act0); end
        end
    endtask

    task automatic test_frames;
        int len, l, e, n, base;
        for (int f = 0; f < 2; f++) begin
            run_line($urandom_range(60, 260), 1);
            for (int i = 0; i < 70; i++) begin
                len = $urandom_range(60, 260);
                l = cur_line;
                e = exp_en(l, len, framed);
                n = (e + 7) / 8;
                base = ((l - 32) / 8) * 16;
                run_line(len, 0);
                tests++; if (en_cnt != e) begin fails++; $display("FAIL frames en_cnt line %0d len %0d got %0d exp %0d", l, len, en_cnt, e); end
                tests++; if (st_cnt != n) begin fails++; $display("FAIL frames st_cnt line %0d got %0d exp %0d", l, st_cnt, n); end
                tests++; if (ld_cnt != n) begin fails++; $display("FAIL frames ld_cnt line %0d got %0d exp %0d", l, ld_cnt, n); end
                tests++; if (gap_bad != 0) begin fails++; $display("FAIL frames start_spacing line %0d got %0d bad exp 0", l, gap_bad); end
                tests++; if (addr_bad != 0) begin fails++; $display("FAIL frames addr_step line %0d got %0d bad exp 0", l, addr_bad); end
                tests++; if (act0 !== in_win(l) || act_var) begin fails++; $display("FAIL frames osd_active line %0d got %b exp %b", l, act0, in_win(l)); end
                if (e > 0) begin
                    tests++; if (first_en != 64 || last_en != 63 + e) begin fails++; $display("FAIL frames en_span line %0d got %0d..%0d exp 64..%0d", l, first_en, last_en, 63 + e); end
                    tests++; if (first_addr != base || last_addr != base + n - 1) begin fails++; $display("FAIL frames addr line %0d got %0d..%0d exp %0d..%0d", l, first_addr, last_addr, base, base + n - 1); end
                end
                if (in_win(l)) begin
                    tests++; if (int'(glyph0) != (l - 32) % 8) begin fails++; $display("FAIL frames glyph_row line %0d got %0d exp %0d", l, glyph0, (l - 32) % 8); end
                end
            end
        end
    endtask

    task automatic test_line45_edges;
        run_line(100, 1);
        for (int i = 0; i < 66; i++) begin
            run_line((i == 31 || i == 45 || i == 64) ? 200 : 70, 0);
            if (i == 31 || i == 64) begin
                tests++; if (en_cnt != 0) begin fails++; $display("FAIL edge en_cnt line %0d got %0d exp 0", i, en_cnt); end
                tests++; if (act0 !== 1'b0) begin fails++; $display("FAIL edge osd_active line %0d got %b exp 0", i, act0); end
            end
            if (i == 45) begin
                tests++; if (glyph0 !== 3'd5) begin fails++; $display("FAIL line45 glyph_row got %0d exp 5", glyph0); end
                tests++; if (first_addr != 16) begin fails++; $display("FAIL line45 first_addr got %0d exp 16", first_addr); end
                tests++; if (last_addr != 31) begin fails++; $display("FAIL line45 last_addr got %0d exp 31", last_addr); end
                tests++; if (en_cnt != 128 || st_cnt != 16) begin fails++; $display("FAIL line45 cells got en %0d st %0d exp 128 16", en_cnt, st_cnt); end
            end
        end
    endtask

    task automatic test_abort;
        run_line(100, 1);
        for (int i = 0; i < 40; i++) run_line(70, 0);
        run_line(85, 0);
        tests++; if (en_cnt != 21) begin fails++; $display("FAIL abort en_cnt got %0d exp 21", en_cnt); end
        tests++; if (st_cnt != 3) begin fails++; $display("FAIL abort st_cnt got %0d exp 3", st_cnt); end
        run_line(200, 0);
        tests++; if (first_en != 64) begin fails++; $display("FAIL abort restart first_en got %0d exp 64", first_en); end
        tests++; if (en_cnt != 128) begin fails++; $display("FAIL abort restart en_cnt got %0d exp 128", en_cnt); end
    endtask

    task automatic test_async_reset;
        run_line(100, 1);
        for (int i = 0; i < 33; i++) run_line(70, 0);
        repeat (100) begin
            @(negedge clk);
            line_start = 0;
            frame_start = 0;
        end
        tests++; if (seg_enable !== 1'b1) begin fails++; $display("FAIL arst pre seg_enable got %b exp 1", seg_enable); end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        tests++; if (seg_enable !== 1'b0) begin fails++; $display("FAIL arst seg_enable got %b exp 0", seg_enable); end
        tests++; if (seg_start !== 1'b0 || char_load !== 1'b0) begin fails++; $display("FAIL arst pulses got %b%b exp 00", seg_start, char_load); end
        tests++; if (osd_active !== 1'b0) begin fails++; $display("FAIL arst osd_active got %b exp 0", osd_active); end
        tests++; if (char_addr !== 10'd0 || glyph_row !== 3'd0) begin fails++; $display("FAIL arst addr/glyph got %0d/%0d exp 0/0", char_addr, glyph_row); end
        @(negedge clk);
        rst_n = 1;
        cur_line = 0;
        framed = 0;
        for (int i = 0; i < 34; i++) begin
            run_line(100, 0);
            tests++; if (en_cnt != 0 || st_cnt != 0) begin fails++; $display("FAIL arst idle line %0d got en %0d st %0d exp 0 0", i, en_cnt, st_cnt); end
        end
    endtask

    initial begin
        test_reset;
        test_no_frame;
        test_frames;
        test_line45_edges;
        test_abort;
        test_async_reset;
        @(negedge clk);
        line_start = 0;
        frame_start = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
